// File: rtl/alarm_ctrl.sv
// alarm_ctrl - alarm setting / ringing sequencer for the alarm clock.
//
// Ports
//   clk            system clock, rising edge
//   CLR_n          asynchronous reset, active-high (despite the name)
//   tick_1hz       one-clk pulse per second
//   key_mode       debounced pulse: step through the setting modes
//   key_adj        debounced pulse: increment selected field / snooze while ringing
//   key_stop       debounced pulse: silence the alarm
//   alarm_en       level, alarm armed when 1
//   cur_time       BCD {hh_t,hh_o,mm_t,mm_o,ss_t,ss_o}
//   alarm_time     BCD {hh_t,hh_o,mm_t,mm_o}
//   isSettingAlarm registered, 1 in SET_HOUR / SET_MIN
//   hour_setting   registered one-clk increment pulse to the alarm hour counter
//   minute_setting registered one-clk increment pulse to the alarm minute counter
//   buzzer         registered beep drive, toggles once per second while ringing
//   ringing        registered, 1 in RING
//   state          current FSM encoding
//
// Build option
//   ALARM_SNOOZE_EN  adds the SNOOZE state (300 s snooze, at most 3 per alarm).
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a key_mode press or an alarm time match
// SET_HOUR | key_adj bumps the alarm hour
// SET_MIN  | key_adj bumps the alarm minute
// RING     | buzzer active, auto-stop after 60 s
// SNOOZE   | silent 300 s countdown, then back to RING

module alarm_ctrl (
  input  logic        clk,
  input  logic        CLR_n,
  input  logic        tick_1hz,
  input  logic        key_mode,
  input  logic        key_adj,
  input  logic        key_stop,
  input  logic        alarm_en,
  input  logic [23:0] cur_time,
  input  logic [15:0] alarm_time,
  output logic        isSettingAlarm,
  output logic        hour_setting,
  output logic        minute_setting,
  output logic        buzzer,
  output logic        ringing,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SET_HOUR = 3'd1,
    S_SET_MIN  = 3'd2,
    S_RING     = 3'd3,
    S_SNOOZE   = 3'd4
  } state_t;

  state_t     st_q, st_d;
  logic [5:0] ring_cnt_q, ring_cnt_d;
  logic       buzzer_d, hour_d, minute_d;
  logic       alarm_match;

`ifdef ALARM_SNOOZE_EN
  logic [8:0] snz_tmr_q, snz_tmr_d;
  logic [1:0] snz_cnt_q, snz_cnt_d;
`endif

  // Match only on the tick that starts second 00 of the alarm minute.
  assign alarm_match = alarm_en & tick_1hz &
                       (cur_time[23:8] == alarm_time) &
                       (cur_time[7:0] == 8'h00);

  assign state = st_q;

  always_comb begin
    st_d       = st_q;
    ring_cnt_d = ring_cnt_q;
    buzzer_d   = 1'b0;
    hour_d     = 1'b0;
    minute_d   = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_tmr_d  = snz_tmr_q;
    snz_cnt_d  = snz_cnt_q;
`endif
    case (st_q)
      S_IDLE: begin
        // key_mode wins over a coincident match; that match is lost.
        if (key_mode) begin
          st_d = S_SET_HOUR;
        end else if (alarm_match) begin
          st_d       = S_RING;
          ring_cnt_d = 6'd0;
          buzzer_d   = 1'b1;
        end
      end
      S_SET_HOUR: begin
        if (key_mode)     st_d   = S_SET_MIN;
        else if (key_adj) hour_d = 1'b1;
      end
      S_SET_MIN: begin
        if (key_mode)     st_d     = S_IDLE;
        else if (key_adj) minute_d = 1'b1;
      end
      S_RING: begin
        buzzer_d = buzzer;
        if (!alarm_en || key_stop) begin
          st_d     = S_IDLE;
          buzzer_d = 1'b0;
        end
`ifdef ALARM_SNOOZE_EN
        else if (key_adj && (snz_cnt_q != 2'd3)) begin
          st_d      = S_SNOOZE;
          buzzer_d  = 1'b0;
          snz_tmr_d = 9'd300;
          snz_cnt_d = snz_cnt_q + 2'd1;
        end
`endif
        else if (tick_1hz) begin
          // Counter holds 59 after 59 ticks, so this is the 60th second.
          if (ring_cnt_q == 6'd59) begin
            st_d     = S_IDLE;
            buzzer_d = 1'b0;
          end else begin
            ring_cnt_d = ring_cnt_q + 6'd1;
            buzzer_d   = ~buzzer;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      S_SNOOZE: begin
        if (!alarm_en || key_stop) begin
          st_d = S_IDLE;
        end else if (tick_1hz) begin
          if (snz_tmr_q <= 9'd1) begin
            st_d       = S_RING;
            snz_tmr_d  = 9'd0;
            ring_cnt_d = 6'd0;
            buzzer_d   = 1'b1;
          end else begin
            snz_tmr_d = snz_tmr_q - 9'd1;
          end
        end
      end
`endif
      default: st_d = S_IDLE;
    endcase
`ifdef ALARM_SNOOZE_EN
    if (st_d == S_IDLE) snz_cnt_d = 2'd0;
`endif
  end

  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      st_q           <= S_IDLE;
      ring_cnt_q     <= 6'd0;
      buzzer         <= 1'b0;
      hour_setting   <= 1'b0;
      minute_setting <= 1'b0;
      isSettingAlarm <= 1'b0;
      ringing        <= 1'b0;
    end else begin
      st_q           <= st_d;
      ring_cnt_q     <= ring_cnt_d;
      buzzer         <= buzzer_d;
      hour_setting   <= hour_d;
      minute_setting <= minute_d;
      isSettingAlarm <= (st_d == S_SET_HOUR) || (st_d == S_SET_MIN);
      ringing        <= (st_d == S_RING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      snz_tmr_q <= 9'd0;
      snz_cnt_q <= 2'd0;
    end else begin
      snz_tmr_q <= snz_tmr_d;
      snz_cnt_q <= snz_cnt_d;
    end
  end
`endif

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  system clock, all state updated on rising edge.
REQ-002 SHALL provide: CLR_n  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: tick_1hz  input  1  one-clk-wide pulse per second, synchronous to clk.
REQ-004 SHALL provide: key_mode  input  1  one-clk pulse, debounced; steps through setting modes.
REQ-005 SHALL provide: key_adj  input  1  one-clk pulse, debounced; increments the selected field, or requests snooze while ringing.
REQ-006 SHALL provide: key_stop  input  1  one-clk pulse, debounced; silences the alarm.
REQ-007 SHALL provide: alarm_en  input  1  level; alarm armed when 1.
REQ-008 SHALL provide: cur_time  input  24  BCD {hh_t,hh_o,mm_t,mm_o,ss_t,ss_o}, 4 bits each.
REQ-009 SHALL provide: alarm_time  input  16  BCD {hh_t,hh_o,mm_t,mm_o} from the alarm hour/minute counters.
REQ-010 SHALL provide: isSettingAlarm  output  1  registered; 1 in SET_HOUR or SET_MIN.
REQ-011 SHALL provide: hour_setting, minute_setting  output  1 each  registered one-clk increment pulses to the alarm counters.
REQ-012 SHALL provide: buzzer  output  1  registered beep drive.
REQ-013 SHALL provide: ringing  output  1  registered; 1 in RING.
REQ-014 SHALL provide: state  output  3  current FSM encoding.

Function
REQ-015 FSM states SHALL be IDLE=0, SET_HOUR=1, SET_MIN=2, RING=3, SNOOZE=4; codes 5-7 SHALL return to IDLE on the next clk.
REQ-016 IDLE: key_mode SHALL go to SET_HOUR; match SHALL go to RING. Match = alarm_en & tick_1hz & cur_time[23:8]==alarm_time & cur_time[7:0]==8'h00.
REQ-017 IDLE: key_mode and match in the same cycle SHALL go to SET_HOUR; that match SHALL be dropped.
REQ-018 SET_HOUR: key_mode SHALL go to SET_MIN; key_adj SHALL assert hour_setting for exactly the next clk.
REQ-019 SET_MIN: key_mode SHALL go to IDLE; key_adj SHALL assert minute_setting for exactly the next clk.
REQ-020 If key_mode and key_adj coincide in a SET state, the transition SHALL occur and no setting pulse SHALL be issued.
REQ-021 No alarm match SHALL be evaluated in SET_HOUR or SET_MIN.
REQ-022 RING entry SHALL clear a 6-bit ring counter; each tick_1hz SHALL increment it and toggle buzzer; buzzer SHALL be 1 in the first RING cycle.
REQ-023 RING SHALL return to IDLE when the ring counter reaches 59 on a tick (60 s auto-stop), on key_stop, or on alarm_en=0.
REQ-024 Priority in RING and SNOOZE: alarm_en=0 > key_stop > key_adj > tick events.
REQ-025 buzzer SHALL be 0 in every state except RING; key_mode SHALL be ignored in RING and SNOOZE.

Reset
REQ-026 CLR_n=1 SHALL immediately force state=IDLE, isSettingAlarm=0, hour_setting=0, minute_setting=0, buzzer=0, ringing=0, and clear the ring, snooze and snooze-count counters.
REQ-027 Reset mid-RING or mid-SNOOZE SHALL leave no pending alarm; after release the block SHALL wait for the next match.

Configuration
REQ-028 With macro ALARM_SNOOZE_EN defined, key_adj in RING SHALL go to SNOOZE, load a 9-bit counter with 300, and increment a 2-bit snooze count.
REQ-029 With ALARM_SNOOZE_EN defined, SNOOZE SHALL decrement the counter on each tick and re-enter RING on reaching 0.
REQ-030 With ALARM_SNOOZE_EN defined, after 3 snoozes key_adj in RING SHALL be ignored; the snooze count SHALL clear on any transition to IDLE.
REQ-031 Without ALARM_SNOOZE_EN, key_adj SHALL be ignored in RING, SNOOZE SHALL be unreachable, and the snooze logic SHALL not be synthesized.

Verification
REQ-032 Bench SHALL cover: key_mode, key_adj x3, key_mode, key_adj x2, key_mode -> exactly 3 hour_setting and 2 minute_setting pulses, each 1 clk wide; isSettingAlarm high only in between; final state=IDLE.
REQ-033 Bench SHALL cover: alarm_time=16'h0730, alarm_en=1, cur_time reaching 24'h073000 with tick -> RING, ringing=1, buzzer toggling per tick, IDLE after 60 ticks.
REQ-034 Bench SHALL cover: the same match with alarm_en=0 -> state remains IDLE, buzzer=0.
REQ-035 Bench SHALL cover: in RING, key_stop and key_adj in the same cycle -> IDLE, buzzer=0, no SNOOZE.
REQ-036 Bench SHALL cover, with ALARM_SNOOZE_EN: key_adj in RING -> SNOOZE, RING re-entered after 300 ticks; 4th key_adj ignored.
REQ-037 Bench SHALL cover: CLR_n pulse mid-RING -> all outputs 0 asynchronously, state=IDLE.
